pipe_stage_buf: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque data bundle and one control bundle between pipeline stages, with a valid/ready handshake in place of a bare clock-through.
- Adds an optional one-entry skid buffer, so in_ready is a registered signal and carries no combinational path from out_ready.
- Keeps the synchronous flush with zeroing, and adds a saturating stall-cycle counter for hazard-unit performance debugging.

---
 rtl/pipe_stage_buf.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic valid/ready pipeline register with optional skid slot,
// synchronous flush and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   flush            synchronous clear of all entries (highest priority)
//   in_valid/ready   upstream handshake; in_ready is registered when SKID=1
//   in_data/ctrl     upstream payload and control bundles
//   out_valid/ready  downstream handshake
//   out_data/ctrl    main-register payload; out_ctrl reads 0 while out_valid=0
//   stall_cnt        cycles with out_valid=1 and out_ready=0, saturating
//   cnt_clr          synchronous clear of stall_cnt
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    localparam bit USE_SKID = (SKID != 0);

    // EMPTY: nothing held; FULL: main register valid;
    // OVER: main and skid both valid (only reachable with SKID=1).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        OVER  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                rdy_q, rdy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                in_xfer;
    logic                stalled;

    assign out_valid = (state_q != EMPTY);

    // With the skid slot, in_ready comes straight from a flop so no
    // combinational path exists from out_ready back to upstream.
    assign in_ready = USE_SKID ? rdy_q
                               : ((state_q == EMPTY) | out_ready);

    assign in_xfer  = in_valid & in_ready;
    assign stalled  = out_valid & ~out_ready;

    assign out_data  = data_q;
    assign out_ctrl  = out_valid ? ctrl_q : '0;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d     = EMPTY;
            data_d      = '0;
            ctrl_d      = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else if (USE_SKID) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        data_d  = in_data;
                        ctrl_d  = in_ctrl;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_xfer) begin
                            data_d = in_data;
                            ctrl_d = in_ctrl;
                        end else begin
                            // out_data keeps its last value;
                            // out_ctrl is masked by out_valid.
                            state_d = EMPTY;
                        end
                    end else if (in_xfer) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = OVER;
                    end
                end
                OVER: begin
                    if (out_ready) begin
                        data_d  = skid_data_q;
                        ctrl_d  = skid_ctrl_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (in_xfer) begin
                data_d  = in_data;
                ctrl_d  = in_ctrl;
                state_d = FULL;
            end else if (out_valid & out_ready) begin
                state_d = EMPTY;
            end
        end
    end

    // Registered ready tracks the next-cycle skid occupancy.
    assign rdy_d = (state_d != OVER);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            ctrl_q      <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf (skid, no-skid,
// and narrow-counter instances) using immediate assertions.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: SKID=1, default widths
    logic         flush = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
    logic [127:0] in_data = '0;
    logic [7:0]   in_ctrl = '0;
    logic         in_ready, out_valid;
    logic [127:0] out_data;
    logic [7:0]   out_ctrl;
    logic [15:0]  stall_cnt;

    pipe_stage_buf u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    // Instance B: SKID=0
    logic         b_in_valid = 0, b_out_ready = 0;
    logic [15:0]  b_in_data = '0;
    logic [3:0]   b_in_ctrl = '0;
    logic         b_in_ready, b_out_valid;
    logic [15:0]  b_out_data;
    logic [3:0]   b_out_ctrl;
    logic [15:0]  b_stall;

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .SKID(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall), .cnt_clr(1'b0)
    );

    // Instance C: CNT_W=3
    logic         c_in_valid = 0;
    logic         c_in_ready, c_out_valid;
    logic [7:0]   c_out_data;
    logic [1:0]   c_out_ctrl;
    logic [2:0]   c_stall;

    pipe_stage_buf #(.DATA_W(8), .CTRL_W(2), .CNT_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(8'h3C), .in_ctrl(2'b01),
        .out_valid(c_out_valid), .out_ready(1'b0),
        .out_data(c_out_data), .out_ctrl(c_out_ctrl),
        .stall_cnt(c_stall), .cnt_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", 128'(out_valid), 128'd0);
        chk("rst_od", out_data, 128'd0);
        chk("rst_oc", 128'(out_ctrl), 128'd0);
        chk("rst_cnt", 128'(stall_cnt), 128'd0);
        chk("rst_rdy_skid", 128'(in_ready), 128'd0);
        chk("rst_rdy_noskid", 128'(b_in_ready), 128'd1);
        rst_n = 1'b1;
        step();
        chk("rdy_after_rst", 128'(in_ready), 128'd1);

        // 1. Single transfer then 8-entry stream
        in_valid = 1; in_data = 128'h1234; in_ctrl = 8'h5A;
        out_ready = 1;
        step();
        chk("t1_ov", 128'(out_valid), 128'd1);
        chk("t1_od", out_data, 128'h1234);
        chk("t1_oc", 128'(out_ctrl), 128'h5A);
        for (int i = 0; i < 8; i++) begin
            in_data = 128'(100 + i); in_ctrl = 8'(i + 1);
            step();
            chk("t1_stream_od", out_data, 128'(100 + i));
            chk("t1_stream_ov", 128'(out_valid), 128'd1);
        end
        in_valid = 0;
        step();
        chk("t1_drain_ov", 128'(out_valid), 128'd0);
        chk("t1_drain_oc", 128'(out_ctrl), 128'd0);
        chk("t1_drain_od", out_data, 128'd107);

        // 2. Skid: A held, B into skid, C ignored
        out_ready = 0; in_valid = 1; in_data = 128'hA; in_ctrl = 8'hA1;
        step();
        chk("t2_a_od", out_data, 128'hA);
        in_data = 128'hB; in_ctrl = 8'hB1;
        step();
        chk("t2_rdy0", 128'(in_ready), 128'd0);
        chk("t2_hold_od", out_data, 128'hA);
        chk("t2_hold_oc", 128'(out_ctrl), 128'hA1);
        in_data = 128'hC; in_ctrl = 8'hC1;
        step();
        chk("t2_hold2_od", out_data, 128'hA);
        chk("t2_cnt", 128'(stall_cnt), 128'd2);
        in_valid = 0; out_ready = 1;
        step();
        chk("t2_b_od", out_data, 128'hB);
        chk("t2_b_oc", 128'(out_ctrl), 128'hB1);
        chk("t2_b_rdy", 128'(in_ready), 128'd1);
        chk("t2_cnt_keep", 128'(stall_cnt), 128'd2);
        step();
        chk("t2_empty", 128'(out_valid), 128'd0);

        // 4. Stall counter
        cnt_clr = 1;
        step();
        chk("t4_clr", 128'(stall_cnt), 128'd0);
        cnt_clr = 0;
        in_valid = 1; in_data = 128'h55; in_ctrl = 8'h55; out_ready = 0;
        step();
        in_valid = 0;
        repeat (5) step();
        chk("t4_cnt5", 128'(stall_cnt), 128'd5);
        chk("t4_od_stable", out_data, 128'h55);
        cnt_clr = 1;
        step();
        chk("t4_clr_prio", 128'(stall_cnt), 128'd0);
        cnt_clr = 0;

        // 3. Flush in OVER
        in_valid = 1; in_data = 128'h66; in_ctrl = 8'h66;
        step();
        chk("t3_over", 128'(in_ready), 128'd0);
        flush = 1; in_data = 128'h77; in_ctrl = 8'h77;
        step();
        chk("t3_ov", 128'(out_valid), 128'd0);
        chk("t3_oc", 128'(out_ctrl), 128'd0);
        chk("t3_od", out_data, 128'd0);
        chk("t3_rdy", 128'(in_ready), 128'd1);
        chk("t3_cnt", 128'(stall_cnt), 128'd2);
        in_data = 128'h88; in_ctrl = 8'h88;
        step();
        flush = 0; in_valid = 0;
        step();
        chk("t3_discard_ov", 128'(out_valid), 128'd0);
        chk("t3_discard_od", out_data, 128'd0);

        // 5. No-skid instance, and 4b. narrow counter in parallel
        b_in_valid = 1; b_in_data = 16'h11; b_in_ctrl = 4'h1;
        c_in_valid = 1;
        step();
        chk("t5_ov", 128'(b_out_valid), 128'd1);
        chk("t5_od", 128'(b_out_data), 128'h11);
        b_in_valid = 0; c_in_valid = 0;
        #1;
        chk("t5_rdy0", 128'(b_in_ready), 128'd0);
        b_out_ready = 1;
        #1;
        chk("t5_rdy1", 128'(b_in_ready), 128'd1);
        b_in_valid = 1; b_in_data = 16'h22; b_in_ctrl = 4'h2;
        step();
        chk("t5_repl_ov", 128'(b_out_valid), 128'd1);
        chk("t5_repl_od", 128'(b_out_data), 128'h22);
        chk("t5_repl_oc", 128'(b_out_ctrl), 128'h2);
        b_in_valid = 0;
        step();
        chk("t5_drain_ov", 128'(b_out_valid), 128'd0);
        chk("t5_drain_oc", 128'(b_out_ctrl), 128'd0);
        repeat (8) step();
        chk("t4_sat", 128'(c_stall), 128'd7);

        // 6. Async reset while OVER
        out_ready = 0; in_valid = 1; in_data = 128'h91; in_ctrl = 8'h91;
        step();
        in_data = 128'h92; in_ctrl = 8'h92;
        step();
        in_valid = 0;
        chk("t6_over", 128'(in_ready), 128'd0);
        #2 rst_n = 0;
        #1;
        chk("t6_ov", 128'(out_valid), 128'd0);
        chk("t6_od", out_data, 128'd0);
        chk("t6_oc", 128'(out_ctrl), 128'd0);
        chk("t6_cnt", 128'(stall_cnt), 128'd0);
        #1 rst_n = 1;
        step();
        chk("t6_rdy", 128'(in_ready), 128'd1);
        in_valid = 1; in_data = 128'h99; in_ctrl = 8'h3C; out_ready = 1;
        step();
        chk("t6_xfer_ov", 128'(out_valid), 128'd1);
        chk("t6_xfer_od", out_data, 128'h99);
        chk("t6_xfer_oc", 128'(out_ctrl), 128'h3C);
        in_valid = 0;
        step();
        chk("t6_done", 128'(out_valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
